// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

   typedef enum logic [3:0] {
      AC_AND = 4'b0000,
      AC_OR  = 4'b0001,
      AC_ADD = 4'b0010,
      AC_SUB = 4'b0110,
      AC_SLT = 4'b0111,
      AC_SLL = 4'b1000,
      AC_SRL = 4'b1001
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_SLT   = 2'b10,
      ALUOP_RTYPE = 2'b11
   } aluop_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_MUL  = 2'b01,
      MDU_DIV  = 2'b10
   } mdu_state_e;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one bit per cycle, WIDTH cycles per operation,
// results land in the HI/LO registers on the final iteration edge.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

   logic               sa, sb;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] step, prod;

   always_comb begin
      sa    = is_signed & a[WIDTH-1];
      sb    = is_signed & b[WIDTH-1];
      a_mag = sa ? -a : a;
      b_mag = sb ? -b : b;

      // work_q holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};

      if (state_q == MDU_MUL)
         step = {mul_sum, work_q[WIDTH-1:1]};
      else if (div_diff[WIDTH])
         step = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
      else
         step = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

      prod = neg_q ? -step : step;
      quo  = dz_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
      rem  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

      state_d = state_q;
      count_d = count_q;
      work_d  = work_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;

      case (state_q)
         MDU_IDLE: begin
            if (start) begin
               state_d = is_div ? MDU_DIV : MDU_MUL;
               count_d = '0;
               work_d  = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
               opnd_d  = is_div ? b_mag : a_mag;
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               dz_d    = is_div & (b == '0);
            end
            if (wr_hi) hi_d = a;
            if (wr_lo) lo_d = a;
         end
         default: begin
            work_d  = step;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = MDU_IDLE;
               if (state_q == MDU_DIV) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MDU_IDLE;
         count_q <= '0;
         work_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         work_q  <= work_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = (state_q != MDU_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: combinational decode and arithmetic, with an iterative MDU
// that stalls only MDU-class instructions while it is busy.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             stall,
   output logic             illegal
);

   alu_ctl_e         ctl;
   logic             is_alu, legal, mdu_fn, start_op, op_div, op_sgn;
   logic             sel_hi, sel_lo, mthi, mtlo, go, busy;
   logic [WIDTH-1:0] alu_y, hi, lo;

   always_comb begin
      ctl      = AC_ADD;
      is_alu   = 1'b0;
      legal    = 1'b1;
      mdu_fn   = 1'b0;
      start_op = 1'b0;
      op_div   = 1'b0;
      op_sgn   = 1'b0;
      sel_hi   = 1'b0;
      sel_lo   = 1'b0;
      mthi     = 1'b0;
      mtlo     = 1'b0;
      case (aluop_e'(aluop))
         ALUOP_ADD: is_alu = 1'b1;
         ALUOP_SUB: begin is_alu = 1'b1; ctl = AC_SUB; end
         ALUOP_SLT: begin is_alu = 1'b1; ctl = AC_SLT; end
         default: begin
            case (funct)
               F_ADD:   begin is_alu = 1'b1; ctl = AC_ADD; end
               F_SUB:   begin is_alu = 1'b1; ctl = AC_SUB; end
               F_AND:   begin is_alu = 1'b1; ctl = AC_AND; end
               F_OR:    begin is_alu = 1'b1; ctl = AC_OR;  end
               F_SLT:   begin is_alu = 1'b1; ctl = AC_SLT; end
               F_SLL:   begin is_alu = 1'b1; ctl = AC_SLL; end
               F_SRL:   begin is_alu = 1'b1; ctl = AC_SRL; end
               F_MULT:  begin mdu_fn = 1'b1; start_op = 1'b1; op_sgn = 1'b1; end
               F_MULTU: begin mdu_fn = 1'b1; start_op = 1'b1; end
               F_DIV:   begin mdu_fn = 1'b1; start_op = 1'b1; op_div = 1'b1; op_sgn = 1'b1; end
               F_DIVU:  begin mdu_fn = 1'b1; start_op = 1'b1; op_div = 1'b1; end
               F_MFHI:  begin mdu_fn = 1'b1; sel_hi = 1'b1; end
               F_MFLO:  begin mdu_fn = 1'b1; sel_lo = 1'b1; end
               F_MTHI:  begin mdu_fn = 1'b1; mthi = 1'b1; end
               F_MTLO:  begin mdu_fn = 1'b1; mtlo = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
      endcase
   end

   always_comb begin
      case (ctl)
         AC_AND:  alu_y = a & b;
         AC_OR:   alu_y = a | b;
         AC_ADD:  alu_y = a + b;
         AC_SUB:  alu_y = a - b;
         AC_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         AC_SLL:  alu_y = b << shamt;
         AC_SRL:  alu_y = b >> shamt;
         default: alu_y = '0;
      endcase

      if (is_alu)      result = alu_y;
      else if (sel_hi) result = hi;
      else if (sel_lo) result = lo;
      else             result = '0;

      zero    = (result == '0);
      stall   = valid & busy & mdu_fn;
      go      = valid & ~stall;
      // reset masks illegal so downstream trap logic stays quiet while held
      illegal = valid & ~legal & ~reset;
   end

   mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk       (clk),
      .reset     (reset),
      .start     (go & start_op),
      .is_div    (op_div),
      .is_signed (op_sgn),
      .wr_hi     (go & mthi),
      .wr_lo     (go & mtlo),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo)
   );

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: the driver queues expected results, the
// monitor checks them whenever an instruction leaves EX (valid & !stall).
module tb_alu_mdu;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_BAD   = 6'b111111;

   logic        clk = 1'b0;
   logic        reset, valid, zero, stall, illegal;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a, b, result;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .valid   (valid),
      .aluop   (aluop),
      .funct   (funct),
      .shamt   (shamt),
      .a       (a),
      .b       (b),
      .result  (result),
      .zero    (zero),
      .stall   (stall),
      .illegal (illegal)
   );

   typedef struct {
      logic [31:0] res;
      logic        ill;
      bit          chk;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b0 && valid === 1'b1 && stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", result);
         end else begin
            e = exp_q.pop_front();
            if (e.chk) begin
               check({e.name, "_result"}, result, e.res);
               check({e.name, "_zero"}, {31'b0, zero}, {31'b0, (e.res == 32'h0)});
            end
            check({e.name, "_illegal"}, {31'b0, illegal}, {31'b0, e.ill});
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] ia, input logic [31:0] ib, input bit chk,
                        input logic [31:0] er, input logic eill, input string nm,
                        output int stalls);
      exp_q.push_back('{res: er, ill: eill, chk: chk, name: nm});
      aluop  = op;
      funct  = fn;
      shamt  = sh;
      a      = ia;
      b      = ib;
      valid  = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (stall === 1'b1 && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: got stall=%b expected 0 within 100 cycles", nm, stall);
      end
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic alu(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] er, input string nm);
      int st;
      issue(op, fn, sh, ia, ib, 1'b1, er, 1'b0, nm, st);
      check({nm, "_stalls"}, st, 32'd0);
   endtask

   task automatic mdu_start(input logic [5:0] fn, input logic [31:0] ia, input logic [31:0] ib,
                            input string nm);
      int st;
      issue(2'b11, fn, 5'd0, ia, ib, 1'b0, 32'h0, 1'b0, nm, st);
      check({nm, "_accept_stalls"}, st, 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stimulus
      int st;
      reset = 1'b1;
      valid = 1'b0;
      aluop = 2'b00;
      funct = 6'b0;
      shamt = 5'd0;
      a     = 32'h0;
      b     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      valid = 1'b1;
      aluop = 2'b11;
      funct = F_BAD;
      #1;
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      aluop = 2'b00;
      a = 32'd7;
      b = 32'd5;
      #1;
      check("rst_result", result, 32'd12);
      valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;

      aluop = 2'b11;
      funct = F_BAD;
      #1;
      check("novalid_illegal", {31'b0, illegal}, 32'd0);
      check("novalid_result", result, 32'd0);

      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reset_hi", st);
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reset_lo", st);

      alu(2'b00, 6'b0, 5'd0, 32'd7, 32'd5, 32'd12, "add");
      alu(2'b01, 6'b0, 5'd0, 32'd5, 32'd7, 32'hFFFFFFFE, "sub");
      alu(2'b10, 6'b0, 5'd0, 32'hFFFFFFFD, 32'd2, 32'd1, "slti");
      alu(2'b11, F_SLL, 5'd31, 32'h0, 32'd1, 32'h80000000, "sll");
      alu(2'b11, F_SRL, 5'd4, 32'h0, 32'h80000000, 32'h08000000, "srl");
      alu(2'b11, F_SLT, 5'd0, 32'd2, 32'hFFFFFFFD, 32'd0, "slt_false");
      alu(2'b11, F_AND, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, "and");
      alu(2'b11, F_OR,  5'd0, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, "or");
      alu(2'b11, F_ADD, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, "add_wrap");

      mdu_start(F_MULT, 32'hFFFFFFFD, 32'd7, "mult");
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFEB, 1'b0, "mult_lo", st);
      check("mult_lo_stalls", st, 32'd32);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, "mult_hi", st);
      check("mult_hi_stalls", st, 32'd0);

      mdu_start(F_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'd1, 1'b0, "multu_hi", st);
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, "multu_lo", st);

      mdu_start(F_DIVU, 32'd100, 32'd7, "divu");
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'd14, 1'b0, "divu_lo", st);
      check("divu_lo_stalls", st, 32'd32);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'd2, 1'b0, "divu_hi", st);

      mdu_start(F_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFD, 1'b0, "div_neg_lo", st);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, "div_neg_hi", st);

      mdu_start(F_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min");
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'h80000000, 1'b0, "div_min_lo", st);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "div_min_hi", st);

      mdu_start(F_DIV, 32'h1234, 32'h0, "div0");
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h1234, 1'b0, "div0_hi", st);
      check("div0_hi_stalls", st, 32'd32);
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, "div0_lo", st);

      // ALU traffic alongside a busy multiply, then reset mid-operation
      mdu_start(F_MULT, 32'd5, 32'd6, "mult_bg");
      for (int i = 0; i < 10; i++) begin
         alu(2'b11, F_ADD, 5'd0, 32'(i * 3), 32'd100, 32'(100 + i * 3), $sformatf("bg_add%0d", i));
      end
      reset = 1'b1;
      #1;
      check("midop_rst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "postrst_hi", st);
      check("postrst_hi_stalls", st, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "postrst_lo", st);

      issue(2'b11, F_MTHI, 5'd0, 32'h0000CAFE, 32'h0, 1'b0, 32'h0, 1'b0, "mthi", st);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0000CAFE, 1'b0, "mthi_read", st);
      issue(2'b11, F_MTLO, 5'd0, 32'h0000BEEF, 32'h0, 1'b0, 32'h0, 1'b0, "mtlo", st);
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, "mtlo_read", st);
      issue(2'b11, F_BAD, 5'd0, 32'h5555, 32'h0, 1'b1, 32'h0, 1'b1, "illegal", st);
      issue(2'b11, F_MFHI, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0000CAFE, 1'b0, "illegal_hi", st);
      issue(2'b11, F_MFLO, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, "illegal_lo", st);

      repeat (2) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
